spi_master_cfg: RTL and testbench
=================================

// Module: spi_master_cfg
// PURPOSE
//  Parametrised SPI master, successor to the fixed 8-bit mode-0 bus master. Adds configurable word
//  width, all four CPOL/CPHA modes, programmable SCLK divider, MSB/LSB-first order and CS_NUM
//  one-hot chip selects. Sits between a parallel host (CPU/FSM) and off-chip SPI slaves.
//  SCLK is a registered divided clock, never a gated copy of clk.
// PARAMETERS
//  DATA_W  8  bits per transfer (2..32)
//  CS_NUM  4  number of active-low chip-select outputs (1..16)
//  DIV_W   8  width of clk_div; SCLK half-period H = clk_div+1 clk cycles
// PORTS
//  clk        in   1              system clock; all logic on posedge
//  rst_n      in   1              asynchronous active-low reset
//  tx_data    in   DATA_W         word to transmit, sampled on start accept
//  cs_sel     in   $clog2(CS_NUM) slave index, sampled on start accept
//  cpol       in   1              SCLK idle level, sampled on start accept
//  cpha       in   1              0: sample leading edge; 1: sample trailing edge
//  lsb_first  in   1              1: bit 0 shifted first
//  clk_div    in   DIV_W          half-period divider, sampled on start accept
//  start      in   1              request; accepted only when busy==0
//  SI         in   1              MISO
//  SO         out  1              MOSI, registered
//  SCLK       out  1              serial clock, registered
//  CS_N       out  CS_NUM         one-hot-low chip selects, registered
//  rx_data    out  DATA_W         last received word
//  rx_valid   out  1              1-cycle pulse when rx_data updates
//  busy       out  1              high while a transfer is in flight
// BEHAVIOUR
//  Reset (async, any time incl. mid-transfer): SO=1, SCLK=0, CS_N=all 1, rx_data=0,
//   rx_valid=0, busy=0, state=IDLE; partial rx word discarded. On release, SCLK takes
//   cpol only at the next start accept.
//  FSM: IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE.
//  IDLE: start=1 at cycle T latches tx_data/cs_sel/cpol/cpha/lsb_first/clk_div; at T+1
//   busy=1, selected CS_N bit=0, SCLK=cpol. CPHA=0: SO=first bit at T+1.
//  SETUP: H cycles of CS lead time, SCLK at idle level.
//  SHIFT: 2*DATA_W SCLK edges, each H cycles apart; edge counter counts down to 0.
//   CPHA=0: sample SI on leading edges, drive next SO bit on trailing edges (not after last).
//   CPHA=1: drive SO on leading edges, sample SI on trailing edges.
//   Bit order from latched lsb_first; rx word assembled in the same order it is sent.
//  HOLD: H cycles, SCLK at idle level, CS_N still asserted (CS lag time).
//  DONE (1 cycle): CS_N=all 1, busy=0, rx_data<=shift reg, rx_valid=1, SO=1.
//  busy high for exactly (2*DATA_W+2)*H cycles, T+1 through the HOLD end; DONE follows.
//  start is ignored while busy=1 (no queueing). start during DONE is accepted, so CS_N
//   min high time between back-to-back transfers = 1 cycle.
//  cs_sel >= CS_NUM: transfer runs fully (dummy clocks) with all CS_N kept high.
//  Config inputs changing mid-transfer have no effect (latched copies only).
//  clk_div=0: SCLK = clk/2. Divider counter is DIV_W bits, reloaded on every edge, no wrap.
// STRUCTURE
//  spi_pkg: state enum (IDLE/SETUP/SHIFT/HOLD/DONE), mode constants SPI_MODE0..3 = {cpol,cpha}.
//  Sub-module spi_clk_gen: divider counter plus lead/trail edge strobes and registered
//   SCLK; the top holds the FSM, shift registers and CS decode.
// TESTING
//  1 DATA_W=8, mode0, clk_div=0, tx 0xA5, SI looped to SO -> rx_data=0xA5, busy 18 cycles, 1 rx_valid pulse
//  2 mode3, lsb_first=1, clk_div=3, tx 0x3C, slave returns 0x81 -> SO bits 0,0,1,1,1,1,0,0;
//    rx_data=0x81; SCLK idles 1, half-period 4 cycles
//  3 cs_sel=2, start pulsed again mid-transfer -> second start ignored, only CS_N[2] low,
//    busy falls once
//  4 start held high continuously -> back-to-back transfers, CS_N high exactly 1 cycle between
//  5 rst_n low at edge 5 of a transfer -> all outputs at reset values at once, no rx_valid;
//    next transfer is clean
//  6 cs_sel=CS_NUM (out of range), tx 0xFF -> 16 SCLK edges, CS_N stays all 1, rx_valid pulses

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the configurable SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } spi_state_e;

  // Mode encodings are {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: half-period divider, registered SCLK and leading/trailing edge strobes.
module spi_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             cpol_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             run_i,
  input  logic             toggle_i,
  output logic             tick_o,
  output logic             lead_o,
  output logic             trail_o,
  output logic             sclk_o
);

  logic [DIV_W-1:0] div_q, cnt_q;
  logic             cpol_q, sclk_q;

  assign tick_o  = run_i && (cnt_q == '0);
  // An edge leaving the idle level is the leading edge of a bit cell
  assign lead_o  = tick_o && toggle_i && (sclk_q == cpol_q);
  assign trail_o = tick_o && toggle_i && (sclk_q != cpol_q);
  assign sclk_o  = sclk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      cnt_q  <= '0;
      cpol_q <= 1'b0;
      sclk_q <= 1'b0;
    end else if (load_i) begin
      div_q  <= div_i;
      cnt_q  <= div_i;
      cpol_q <= cpol_i;
      sclk_q <= cpol_i;
    end else if (run_i) begin
      if (cnt_q == '0) begin
        cnt_q <= div_q;
        if (toggle_i) sclk_q <= ~sclk_q;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master_cfg.sv
// Configurable SPI master: word width, CPOL/CPHA, SCLK divider, bit order, one-hot chip selects.
module spi_master_cfg
  import spi_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int CS_NUM = 4,
  parameter  int DIV_W  = 8,
  localparam int CSW    = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CSW-1:0]    cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              start,
  input  logic              SI,
  output logic              SO,
  output logic              SCLK,
  output logic [CS_NUM-1:0] CS_N,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
);

  localparam int ECW = $clog2(2 * DATA_W);

  spi_state_e        state_q, state_d;
  logic              accept, in_xfer, tick, lead, trail, sample;
  logic [DATA_W-1:0] tx_q, rx_q, rx_data_q, tx_ord;
  logic [ECW-1:0]    edge_q;
  logic              cpha_q, lsb_q, so_q;
  logic [CS_NUM-1:0] cs_n_q, cs_dec;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
    return r;
  endfunction

  assign in_xfer = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
  assign accept  = start && ((state_q == IDLE) || (state_q == DONE));
  // Words are always shifted MSB-first internally; LSB-first is a reversal at the edges
  assign tx_ord  = lsb_first ? bit_rev(tx_data) : tx_data;
  assign sample  = cpha_q ? trail : lead;

  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < CS_NUM; i++)
      if (cs_sel == CSW'(i)) cs_dec[i] = 1'b0;
  end

  spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (accept),
    .cpol_i   (cpol),
    .div_i    (clk_div),
    .run_i    (in_xfer),
    .toggle_i (state_q == SHIFT),
    .tick_o   (tick),
    .lead_o   (lead),
    .trail_o  (trail),
    .sclk_o   (SCLK)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   if (tick) state_d = SHIFT;
      SHIFT:   if (tick && (edge_q == '0)) state_d = HOLD;
      HOLD:    if (tick) state_d = DONE;
      DONE:    state_d = start ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      edge_q    <= '0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      so_q      <= 1'b1;
      cs_n_q    <= '1;
    end else if (accept) begin
      cpha_q <= cpha;
      lsb_q  <= lsb_first;
      cs_n_q <= cs_dec;
      rx_q   <= '0;
      edge_q <= ECW'(2 * DATA_W - 1);
      // CPHA=0 presents bit 0 immediately, CPHA=1 waits for the first leading edge
      tx_q   <= cpha ? tx_ord : (tx_ord << 1);
      so_q   <= cpha ? 1'b1 : tx_ord[DATA_W-1];
    end else if ((state_q == HOLD) && tick) begin
      rx_data_q <= lsb_q ? bit_rev(rx_q) : rx_q;
      cs_n_q    <= '1;
      so_q      <= 1'b1;
    end else if (lead || trail) begin
      if (edge_q != '0) edge_q <= edge_q - 1'b1;
      if (sample) begin
        rx_q <= {rx_q[DATA_W-2:0], SI};
      end else if (cpha_q || (edge_q != '0)) begin
        so_q <= tx_q[DATA_W-1];
        tx_q <= tx_q << 1;
      end
    end
  end

  assign SO       = so_q;
  assign CS_N     = cs_n_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = (state_q == DONE);
  assign busy     = in_xfer;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed bench for spi_master_cfg: expected transfers queued by stimulus, checked by a monitor.
`timescale 1ns/1ps
module tb_spi_master_cfg;

  localparam int DW   = 8;
  localparam int CSN  = 5;
  localparam int DIVW = 8;
  localparam int CSW  = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [DW-1:0]   tx_data = '0;
  logic [CSW-1:0]  cs_sel = '0;
  logic            cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic [DIVW-1:0] clk_div = '0;
  logic            start = 1'b0;
  logic            SI_w, SO, SCLK, rx_valid, busy;
  logic [CSN-1:0]  CS_N;
  logic [DW-1:0]   rx_data;

  logic loop_mode = 1'b1;
  logic slv_si    = 1'b1;
  assign SI_w = loop_mode ? SO : slv_si;

  always #5 clk = ~clk;

  spi_master_cfg #(.DATA_W(DW), .CS_NUM(CSN), .DIV_W(DIVW)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .clk_div(clk_div), .start(start), .SI(SI_w), .SO(SO), .SCLK(SCLK),
    .CS_N(CS_N), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
  );

  typedef struct {
    logic [DW-1:0]  rx, so, slv;
    logic           cpol, cpha, lsb;
    int             busy, h, csgap;
    logic [CSN-1:0] cs;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] rx, input logic [DW-1:0] so, input logic [DW-1:0] slv,
                      input logic [1:0] mode, input logic lsb, input int h,
                      input logic [CSN-1:0] cs, input int csgap);
    exp_t e;
    e.rx = rx; e.so = so; e.slv = slv; e.cpol = mode[1]; e.cpha = mode[0]; e.lsb = lsb;
    e.h = h; e.busy = (2 * DW + 2) * h; e.cs = cs; e.csgap = csgap;
    q.push_back(e);
  endtask

  task automatic xfer(input logic [DW-1:0] tx, input logic [CSW-1:0] cs, input logic [1:0] mode,
                      input logic lsb, input logic [DIVW-1:0] div);
    @(negedge clk);
    tx_data = tx; cs_sel = cs; {cpol, cpha} = mode; lsb_first = lsb; clk_div = div; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ((q.size() == 0) && !busy) break;
    end
    chk({nm, "_drain"}, q.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_SO"}, SO, 1);
    chk({nm, "_SCLK"}, SCLK, 0);
    chk({nm, "_CS_N"}, CS_N, {CSN{1'b1}});
    chk({nm, "_rx_data"}, rx_data, 0);
    chk({nm, "_rx_valid"}, rx_valid, 0);
    chk({nm, "_busy"}, busy, 0);
  endtask

  // Monitor: measures each transfer on the pins, acts as a CPHA=1 slave, checks on rx_valid
  initial begin : monitor
    int bcnt, ecnt, gap, gmin, gmax, hrun, csgap, k;
    logic [DW-1:0]  sow;
    logic [CSN-1:0] csm;
    logic           sprev, bprev, smp;
    exp_t           e;
    bcnt = 0; ecnt = 0; gap = 0; gmin = 1000000; gmax = 0; hrun = 0; csgap = -1;
    sow = '0; csm = '0; sprev = 1'b0; bprev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bcnt = 0; ecnt = 0; gap = 0; gmin = 1000000; gmax = 0; csgap = -1;
        sow = '0; csm = '0; sprev = SCLK; bprev = 1'b0;
      end else begin
        if (busy) begin
          bcnt++;
          csm |= ~CS_N;
        end
        gap++;
        if (busy && bprev && (SCLK != sprev)) begin
          ecnt++;
          if (ecnt > 1) begin
            if (gap < gmin) gmin = gap;
            if (gap > gmax) gmax = gap;
          end
          gap = 0;
          if (q.size() > 0) begin
            e = q[0];
            smp = ((ecnt % 2) == 1) ^ e.cpha;
            if (smp) sow = e.lsb ? {SO, sow[DW-1:1]} : {sow[DW-2:0], SO};
            if (e.cpha && ((ecnt % 2) == 1)) begin
              k = (ecnt - 1) / 2;
              slv_si = e.lsb ? e.slv[k] : e.slv[DW-1-k];
            end
          end
        end
        if (&CS_N) hrun++;
        else begin
          if (hrun > 0) csgap = hrun;
          hrun = 0;
        end
        if (rx_valid) begin
          if (q.size() == 0) chk("unexpected_rx_valid", 1, 0);
          else begin
            e = q.pop_front();
            chk("rx_data", rx_data, e.rx);
            chk("busy_cycles", bcnt, e.busy);
            chk("sclk_edges", ecnt, 2 * DW);
            chk("cs_low_mask", csm, e.cs);
            chk("so_word", sow, e.so);
            chk("sclk_idle", SCLK, e.cpol);
            chk("half_period_min", gmin, e.h);
            chk("half_period_max", gmax, e.h);
            chk("done_cs_n", CS_N, {CSN{1'b1}});
            chk("done_so", SO, 1);
            if (e.csgap >= 0) chk("cs_high_gap", csgap, e.csgap);
          end
          bcnt = 0; ecnt = 0; gap = 0; gmin = 1000000; gmax = 0; csgap = -1;
          sow = '0; csm = '0;
        end
        sprev = SCLK;
        bprev = busy;
      end
    end
  end

  initial begin : stim
    int n;
    logic sp;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // 1: mode0, fastest clock, loopback
    push(8'hA5, 8'hA5, 8'h00, 2'b00, 1'b0, 1, 5'b00001, -1);
    xfer(8'hA5, 3'd0, 2'b00, 1'b0, 8'd0);
    wait_drain("t1");

    // 2: mode3, LSB first, H=4, slave returns 0x81
    loop_mode = 1'b0;
    push(8'h81, 8'h3C, 8'h81, 2'b11, 1'b1, 4, 5'b00001, -1);
    xfer(8'h3C, 3'd0, 2'b11, 1'b1, 8'd3);
    wait_drain("t2");
    loop_mode = 1'b1;

    // 3: cs_sel=2, a second start mid-transfer must be ignored
    push(8'h5A, 8'h5A, 8'h00, 2'b00, 1'b0, 2, 5'b00100, -1);
    xfer(8'h5A, 3'd2, 2'b00, 1'b0, 8'd1);
    repeat (10) @(negedge clk);
    tx_data = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("t3");

    // 4: start held high gives back-to-back transfers with one CS_N-high cycle
    push(8'hC3, 8'hC3, 8'h00, 2'b01, 1'b0, 1, 5'b00001, -1);
    push(8'hC3, 8'hC3, 8'h00, 2'b01, 1'b0, 1, 5'b00001, 1);
    @(negedge clk);
    tx_data = 8'hC3; cs_sel = 3'd0; {cpol, cpha} = 2'b01; lsb_first = 1'b0; clk_div = 8'd0;
    start = 1'b1;
    n = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (rx_valid) break;
    end
    chk("t4_first_done", rx_valid, 1);
    @(negedge clk);
    chk("t4_restart_busy", busy, 1);
    start = 1'b0;
    wait_drain("t4");

    // 5: reset after the 5th SCLK edge aborts cleanly
    xfer(8'h33, 3'd1, 2'b10, 1'b0, 8'd1);
    n = 0;
    sp = SCLK;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (SCLK != sp) n++;
      sp = SCLK;
      if (n == 5) break;
    end
    chk("t5_edges_before_reset", n, 5);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t5_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push(8'h96, 8'h96, 8'h00, 2'b00, 1'b0, 1, 5'b00010, -1);
    xfer(8'h96, 3'd1, 2'b00, 1'b0, 8'd0);
    wait_drain("t5");

    // 6: out-of-range chip select still clocks the full word
    push(8'hFF, 8'hFF, 8'h00, 2'b00, 1'b0, 1, 5'b00000, -1);
    xfer(8'hFF, 3'd5, 2'b00, 1'b0, 8'd0);
    wait_drain("t6");

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
